aes128_decrypt_iter: RTL and testbench

//  Iterative AES-128 inverse cipher (FIPS-197 sec. 5.3), the receive-side counterpart of the encrypt datapath.

---
 rtl/aes_pkg.sv | 101 ++++++++++
 rtl/aes_sbox.sv | 33 +++
 rtl/aes128_decrypt_iter.sv | 179 +++++++++++++++++
 tb/tb_aes128_decrypt_iter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, FSM encoding, key-schedule constants and GF(2^8) helpers
package aes_pkg;

    // s[r][c]; the byte at vector position r + 4*c (counted from the MSB) is s[r][c]
    typedef logic [0:3][0:3][7:0] state_t;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_KEYEXP = 3'd1;
    localparam logic [2:0] S_ADD0   = 3'd2;
    localparam logic [2:0] S_ROUND  = 3'd3;
    localparam logic [2:0] S_FINAL  = 3'd4;

    // index 0 is unused so RCON[i] is the constant for round i
    localparam logic [0:10][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // padded to 16 entries so any 4-bit round number indexes in range
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [0:15][7:0] tab;
        tab = {RCON, 40'h0};
        return tab[idx];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gmulb(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x8;
        x2 = xtime(b);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gmuld(input logic [7:0] b);
        logic [7:0] x4;
        logic [7:0] x8;
        x4 = xtime(xtime(b));
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gmule(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    function automatic state_t to_state(input logic [127:0] v);
        state_t s;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = v[127 - 8 * (r + 4 * c) -: 8];
        return s;
    endfunction

    function automatic logic [127:0] from_state(input state_t s);
        logic [127:0] v;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                v[127 - 8 * (r + 4 * c) -: 8] = s[r][c];
        return v;
    endfunction

    // row r rotates right by r positions
    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[r][(c + r) % 4] = s[r][c];
        return o;
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++) begin
            o[0][c] = gmule(s[0][c]) ^ gmulb(s[1][c]) ^ gmuld(s[2][c]) ^ gmul9(s[3][c]);
            o[1][c] = gmul9(s[0][c]) ^ gmule(s[1][c]) ^ gmulb(s[2][c]) ^ gmuld(s[3][c]);
            o[2][c] = gmuld(s[0][c]) ^ gmul9(s[1][c]) ^ gmule(s[2][c]) ^ gmulb(s[3][c]);
            o[3][c] = gmulb(s[0][c]) ^ gmuld(s[1][c]) ^ gmul9(s[2][c]) ^ gmule(s[3][c]);
        end
        return o;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES S-box ROM, forward or inverse selected by INV
module aes_sbox #(
    parameter bit INV = 1'b0
) (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [0:255][7:0] FWD_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_TAB = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    assign dout = INV ? INV_TAB[din] : FWD_TAB[din];

endmodule

// File: rtl/aes128_decrypt_iter.sv
// rtl/aes128_decrypt_iter.sv - iterative AES-128 inverse cipher, one round per clock, on-the-fly reverse key schedule
module aes128_decrypt_iter
    import aes_pkg::*;
#(
    parameter int NR        = 10,
    parameter bit KEY_CACHE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [127:0] key,
    input  logic [127:0] cipher,
    output logic [127:0] word,
    output logic         busy,
    output logic         done
);

    if (NR != 10) begin : g_nr_check
        $error("aes128_decrypt_iter: NR must be 10");
    end

    localparam logic [3:0] LAST_RND = 4'(NR);

    logic [2:0]   state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] st_q, st_d;
    logic [127:0] word_q, word_d;
    logic         done_q, done_d;
    logic         cache_valid_q, cache_valid_d;
    logic [127:0] cache_key_q, cache_key_d;
    logic [127:0] cache_rk_q, cache_rk_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  sw_in, sw_out, rc_word;
    logic [31:0]  f0, f1, f2, f3;
    logic [31:0]  i0, i1, i2, i3;
    logic [127:0] rk_fwd, rk_inv;
    logic [127:0] sr_vec, isb_vec, round_vec, final_vec;
    logic         cache_hit;

    // SubWord input: forward expansion uses the current w3, reverse uses the
    // already-recovered previous w3 (w3 ^ w2); one set of S-boxes serves both
    always_comb begin
        w0      = rk_q[127:96];
        w1      = rk_q[95:64];
        w2      = rk_q[63:32];
        w3      = rk_q[31:0];
        sw_in   = (state_q == S_KEYEXP) ? rot_word(w3) : rot_word(w3 ^ w2);
        rc_word = {rcon((state_q == S_ADD0) ? LAST_RND : rnd_q), 24'h000000};
    end

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox #(.INV(1'b0)) u_sbox (
            .din  (sw_in[8*i +: 8]),
            .dout (sw_out[8*i +: 8])
        );
    end

    // next round key going forward and previous round key going backward
    always_comb begin
        f0     = w0 ^ sw_out ^ rc_word;
        f1     = w1 ^ f0;
        f2     = w2 ^ f1;
        f3     = w3 ^ f2;
        rk_fwd = {f0, f1, f2, f3};
        i3     = w3 ^ w2;
        i2     = w2 ^ w1;
        i1     = w1 ^ w0;
        i0     = w0 ^ sw_out ^ rc_word;
        rk_inv = {i0, i1, i2, i3};
    end

    assign sr_vec = from_state(inv_shift_rows(to_state(st_q)));

    for (genvar i = 0; i < 16; i++) begin : g_invsub
        aes_sbox #(.INV(1'b1)) u_sbox (
            .din  (sr_vec[8*i +: 8]),
            .dout (isb_vec[8*i +: 8])
        );
    end

    assign round_vec = from_state(inv_mix_columns(to_state(isb_vec ^ rk_q)));
    assign final_vec = isb_vec ^ rk_q;
    assign cache_hit = KEY_CACHE && cache_valid_q && (key == cache_key_q);

    // control FSM and datapath next-state
    always_comb begin
        state_d       = state_q;
        rnd_d         = rnd_q;
        rk_d          = rk_q;
        ct_d          = ct_q;
        st_d          = st_q;
        word_d        = word_q;
        done_d        = 1'b0;
        cache_valid_d = cache_valid_q;
        cache_key_d   = cache_key_q;
        cache_rk_d    = cache_rk_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    ct_d  = cipher;
                    rnd_d = 4'd1;
                    if (cache_hit) begin
                        rk_d    = cache_rk_q;
                        state_d = S_ADD0;
                    end else begin
                        rk_d          = key;
                        cache_key_d   = key;
                        cache_valid_d = 1'b0;
                        state_d       = S_KEYEXP;
                    end
                end
            end
            S_KEYEXP: begin
                rk_d  = rk_fwd;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == LAST_RND) begin
                    cache_rk_d    = rk_fwd;
                    cache_valid_d = KEY_CACHE;
                    state_d       = S_ADD0;
                end
            end
            S_ADD0: begin
                st_d    = ct_q ^ rk_q;
                rk_d    = rk_inv;
                rnd_d   = LAST_RND - 4'd1;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                st_d  = round_vec;
                rk_d  = rk_inv;
                rnd_d = rnd_q - 4'd1;
                if (rnd_q == 4'd1)
                    state_d = S_FINAL;
            end
            S_FINAL: begin
                word_d  = final_vec;
                done_d  = 1'b1;
                rnd_d   = 4'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state registers with synchronous reset; reset also forgets the cached key
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rnd_q         <= 4'd0;
            rk_q          <= '0;
            ct_q          <= '0;
            st_q          <= '0;
            word_q        <= '0;
            done_q        <= 1'b0;
            cache_valid_q <= 1'b0;
            cache_key_q   <= '0;
            cache_rk_q    <= '0;
        end else begin
            state_q       <= state_d;
            rnd_q         <= rnd_d;
            rk_q          <= rk_d;
            ct_q          <= ct_d;
            st_q          <= st_d;
            word_q        <= word_d;
            done_q        <= done_d;
            cache_valid_q <= cache_valid_d;
            cache_key_q   <= cache_key_d;
            cache_rk_q    <= cache_rk_d;
        end
    end

    assign word = word_q;
    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// tb/tb_aes128_decrypt_iter.sv - self-checking bench for aes128_decrypt_iter against a byte-level AES model
module tb_aes128_decrypt_iter;

    logic         clk;
    logic         rst;
    logic         en;
    logic [127:0] key;
    logic [127:0] cipher;
    logic [127:0] word;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    logic [7:0] sbox_m  [256];
    logic [7:0] isbox_m [256];

    logic         m_cache_valid = 1'b0;
    logic [127:0] m_cache_key   = '0;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

    aes128_decrypt_iter #(.NR(10), .KEY_CACHE(1'b1)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .key    (key),
        .cipher (cipher),
        .word   (word),
        .busy   (busy),
        .done   (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] s;
            logic [7:0] xb;
            xb  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(xb, 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_m[x]  = s;
            isbox_m[s] = xb;
        end
    endtask

    function automatic logic [127:0] ref_decrypt(input logic [127:0] k, input logic [127:0] ct);
        logic [31:0]  w [44];
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]}
                      ^ {rc, 24'h000000};
                rc  = gm(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int i = 0; i < 16; i++)
            b[i] = ct[127 - 8 * i -: 8] ^ w[40 + i / 4][31 - 8 * (i % 4) -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r + 4 * ((c + r) % 4)] = isbox_m[b[r + 4 * c]];
            for (int i = 0; i < 16; i++)
                b[i] = t[i] ^ w[4 * rnd + i / 4][31 - 8 * (i % 4) -: 8];
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = b[4 * c]; a1 = b[4 * c + 1]; a2 = b[4 * c + 2]; a3 = b[4 * c + 3];
                    b[4 * c]     = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
                    b[4 * c + 1] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
                    b[4 * c + 2] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
                    b[4 * c + 3] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
                end
            end
        end
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = b[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int exp_latency(input logic [127:0] k);
        return (m_cache_valid && k == m_cache_key) ? 11 : 21;
    endfunction

    // starts a block from a sampling point, returns the result, edges to done and busy cycles
    task automatic run_block(input logic [127:0] k, input logic [127:0] c,
                             output logic [127:0] w, output int lat, output int bcnt);
        key    = k;
        cipher = c;
        en     = 1'b1;
        @(posedge clk); #1;
        en     = 1'b0;
        key    = rand128();
        cipher = rand128();
        lat    = 0;
        bcnt   = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
            if (busy === 1'b1) bcnt++;
        end
        if (done !== 1'b1) lat = -1;
        w = word;
        m_cache_valid = 1'b1;
        m_cache_key   = k;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; key = KEY_A; cipher = CT_A;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (word !== 128'h0) begin bad++; $display("FAIL reset_word got=%h exp=0", word); end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_fips_c1();
        logic [127:0] w; int lat, bc, el;
        el = exp_latency(KEY_A);
        run_block(KEY_A, CT_A, w, lat, bc);
        total++; if (w !== PT_A) begin bad++; $display("FAIL c1_word got=%h exp=%h", w, PT_A); end
        total++; if (lat != el) begin bad++; $display("FAIL c1_latency got=%0d exp=%0d", lat, el); end
        total++; if (bc != el) begin bad++; $display("FAIL c1_busy_cycles got=%0d exp=%0d", bc, el); end
    endtask

    task automatic test_fips_b_and_cache();
        logic [127:0] w; int lat, bc, el;
        el = exp_latency(KEY_B);
        run_block(KEY_B, CT_B, w, lat, bc);
        total++; if (w !== PT_B) begin bad++; $display("FAIL b_word got=%h exp=%h", w, PT_B); end
        total++; if (lat != el) begin bad++; $display("FAIL b_latency got=%0d exp=%0d", lat, el); end
        el = exp_latency(KEY_B);
        run_block(KEY_B, CT_B, w, lat, bc);
        total++; if (w !== PT_B) begin bad++; $display("FAIL hit_word got=%h exp=%h", w, PT_B); end
        total++; if (lat != el) begin bad++; $display("FAIL hit_latency got=%0d exp=%0d", lat, el); end
        total++; if (bc != el) begin bad++; $display("FAIL hit_busy_cycles got=%0d exp=%0d", bc, el); end
    endtask

    task automatic test_en_while_busy();
        logic [127:0] k, c, ex, w0;
        int dones, first, consec;
        logic prev;
        k = rand128(); c = rand128(); ex = ref_decrypt(k, c);
        key = k; cipher = c; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        dones = 0; first = -1; consec = 0; prev = 1'b0; w0 = '0;
        for (int n = 1; n <= 40; n++) begin
            key = rand128(); cipher = rand128();
            en = (n == 3 || n == 7 || n == 15);
            @(posedge clk); #1;
            en = 1'b0;
            if (done === 1'b1) begin
                dones++;
                if (prev) consec++;
                if (first < 0) begin first = n; w0 = word; end
            end
            prev = (done === 1'b1);
        end
        m_cache_valid = 1'b1; m_cache_key = k;
        total++; if (dones != 1) begin bad++; $display("FAIL busy_en_done_count got=%0d exp=1", dones); end
        total++; if (first != 21) begin bad++; $display("FAIL busy_en_latency got=%0d exp=21", first); end
        total++; if (w0 !== ex) begin bad++; $display("FAIL busy_en_word got=%h exp=%h", w0, ex); end
        total++; if (consec != 0) begin bad++; $display("FAIL done_consecutive got=%0d exp=0", consec); end
        total++; if (word !== ex) begin bad++; $display("FAIL word_hold got=%h exp=%h", word, ex); end
    endtask

    task automatic test_reset_mid_op();
        logic [127:0] w; int lat, bc, el, seen;
        run_block(KEY_A, CT_A, w, lat, bc);
        key = KEY_A; cipher = CT_A; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_cache_valid = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", done); end
        total++; if (word !== 128'h0) begin bad++; $display("FAIL midrst_word got=%h exp=0", word); end
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL midrst_stray_done got=%0d exp=0", seen); end
        el = exp_latency(KEY_A);
        run_block(KEY_A, CT_A, w, lat, bc);
        total++; if (w !== PT_A) begin bad++; $display("FAIL midrst_word_after got=%h exp=%h", w, PT_A); end
        total++; if (lat != el) begin bad++; $display("FAIL midrst_latency got=%0d exp=%0d", lat, el); end
    endtask

    task automatic test_random_back_to_back();
        logic [127:0] k, c, w, ex; int lat, bc, el;
        k = rand128();
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(3, 0) != 0) k = rand128();
            c  = rand128();
            ex = ref_decrypt(k, c);
            el = exp_latency(k);
            run_block(k, c, w, lat, bc);
            total++;
            if (w !== ex) begin bad++; $display("FAIL rand_word n=%0d got=%h exp=%h", n, w, ex); end
            total++;
            if (lat != el) begin bad++; $display("FAIL rand_latency n=%0d got=%0d exp=%0d", n, lat, el); end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; key = '0; cipher = '0;
        build_sbox();
        test_reset();
        test_fips_c1();
        test_fips_b_and_cache();
        test_en_while_busy();
        test_reset_mid_op();
        test_random_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
